// File: rtl/lenet_pkg.sv
// Shared LeNet geometry: feature width, map sizes and f2 write count.
package lenet_pkg;

  localparam int DW        = 16;  // signed feature data width
  localparam int IN_W      = 28;  // conv1 map width/height
  localparam int OUT_W     = 14;  // pooled map width/height
  localparam int AW        = 10;  // f2 write-address width
  localparam int F2_WRITES = 196; // pooled pixels per frame
  localparam int N_CH      = 6;   // conv1 / f2 channels

endpackage

// File: rtl/pool_max2.sv
// Combinational signed max of two values. A tie returns a, which equals b.
module pool_max2 #(
  parameter int DW = 16
) (
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] y
);

  assign y = (a >= b) ? a : b;

endmodule

// File: rtl/pool1_f2_writer.sv
// 2x2 max-pool of the 6-channel conv1 raster stream, written into the f2 RAM.
// Horizontal pairs are reduced through a holding register; even rows park
// their row-max in a register line buffer which odd rows then reduce against.
module pool1_f2_writer #(
  parameter int DW    = lenet_pkg::DW,
  parameter int IN_W  = lenet_pkg::IN_W,
  parameter int OUT_W = lenet_pkg::OUT_W,
  parameter int AW    = lenet_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 c1_clr,
  input  logic                 c1_valid,
  input  logic signed [DW-1:0] c1_1_data,
  input  logic signed [DW-1:0] c1_2_data,
  input  logic signed [DW-1:0] c1_3_data,
  input  logic signed [DW-1:0] c1_4_data,
  input  logic signed [DW-1:0] c1_5_data,
  input  logic signed [DW-1:0] c1_6_data,
  output logic signed [DW-1:0] f2_1_wdata,
  output logic signed [DW-1:0] f2_2_wdata,
  output logic signed [DW-1:0] f2_3_wdata,
  output logic signed [DW-1:0] f2_4_wdata,
  output logic signed [DW-1:0] f2_5_wdata,
  output logic signed [DW-1:0] f2_6_wdata,
  output logic                 f2_wr_en,
  output logic [AW-1:0]        f2_waddr,
  output logic                 f2_done
);

  localparam int NCH = lenet_pkg::N_CH;
  localparam int CW  = $clog2(IN_W);
  localparam int LW  = $clog2(OUT_W);
  localparam logic [CW-1:0] LAST_POS  = CW'(IN_W - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(lenet_pkg::F2_WRITES - 1);

  logic signed [DW-1:0] pix     [NCH];
  logic signed [DW-1:0] h       [NCH];
  logic signed [DW-1:0] p       [NCH];
  logic signed [DW-1:0] lb_rd   [NCH];
  logic signed [DW-1:0] hold_q  [NCH];
  logic signed [DW-1:0] hold_d  [NCH];
  logic signed [DW-1:0] lb_q    [NCH][OUT_W];
  logic signed [DW-1:0] lb_d    [NCH][OUT_W];
  logic signed [DW-1:0] wdata_q [NCH];
  logic signed [DW-1:0] wdata_d [NCH];

  logic [CW-1:0] c_q, c_d, r_q, r_d;
  logic [AW-1:0] waddr_q, waddr_d, addr_calc;
  logic          wr_en_q, wr_en_d, done_q, done_d;
  logic          accept;
  logic [LW-1:0] col_idx;

  assign pix[0] = c1_1_data;
  assign pix[1] = c1_2_data;
  assign pix[2] = c1_3_data;
  assign pix[3] = c1_4_data;
  assign pix[4] = c1_5_data;
  assign pix[5] = c1_6_data;

  // A cleared cycle never counts as a pixel, even with c1_valid high.
  assign accept    = c1_valid & ~c1_clr;
  assign col_idx   = LW'(c_q >> 1);
  assign addr_calc = AW'(r_q >> 1) * AW'(OUT_W) + AW'(c_q >> 1);

  // Per-channel horizontal and vertical max stages.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign lb_rd[k] = lb_q[k][col_idx];

    pool_max2 #(.DW(DW)) u_hmax (.a(hold_q[k]), .b(pix[k]), .y(h[k]));
    pool_max2 #(.DW(DW)) u_vmax (.a(lb_rd[k]),  .b(h[k]),   .y(p[k]));
  end

  // Raster position: column wraps into row, row wraps into the next frame.
  always_comb begin
    c_d = c_q;
    r_d = r_q;
    if (c1_clr) begin
      c_d = '0;
      r_d = '0;
    end else if (c1_valid) begin
      if (c_q == LAST_POS) begin
        c_d = '0;
        r_d = (r_q == LAST_POS) ? '0 : r_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  // Even columns fill the holding register; odd columns on even rows fill the line buffer.
  always_comb begin
    hold_d = hold_q;
    lb_d   = lb_q;
    if (accept) begin
      for (int k = 0; k < NCH; k++) begin
        if (!c_q[0]) begin
          hold_d[k] = pix[k];
        end else if (!r_q[0]) begin
          lb_d[k][col_idx] = h[k];
        end
      end
    end
  end

  // Write strobe on odd/odd pixels; address and data hold between writes.
  always_comb begin
    wr_en_d = 1'b0;
    done_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (accept && c_q[0] && r_q[0]) begin
      wr_en_d = 1'b1;
      waddr_d = addr_calc;
      wdata_d = p;
      done_d  = (addr_calc == LAST_ADDR);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q     <= '0;
      r_q     <= '0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      waddr_q <= '0;
      for (int k = 0; k < NCH; k++) begin
        hold_q[k]  <= '0;
        wdata_q[k] <= '0;
        for (int j = 0; j < OUT_W; j++) begin
          lb_q[k][j] <= '0;
        end
      end
    end else begin
      c_q     <= c_d;
      r_q     <= r_d;
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
      waddr_q <= waddr_d;
      hold_q  <= hold_d;
      lb_q    <= lb_d;
      wdata_q <= wdata_d;
    end
  end

  assign f2_wr_en   = wr_en_q;
  assign f2_done    = done_q;
  assign f2_waddr   = waddr_q;
  assign f2_1_wdata = wdata_q[0];
  assign f2_2_wdata = wdata_q[1];
  assign f2_3_wdata = wdata_q[2];
  assign f2_4_wdata = wdata_q[3];
  assign f2_5_wdata = wdata_q[4];
  assign f2_6_wdata = wdata_q[5];

endmodule

// File: tb/tb_pool1_f2_writer.sv
// Self-checking bench for pool1_f2_writer: a reference 2x2 max model pushes
// expected writes into a queue as pixels are driven; a monitor pops them.
module tb_pool1_f2_writer;

  localparam int NPIX = 784;

  typedef struct {
    logic [9:0]       addr;
    logic [5:0][15:0] d;
    logic             done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, c1_clr, c1_valid;
  logic signed [15:0] c1_1_data, c1_2_data, c1_3_data, c1_4_data, c1_5_data, c1_6_data;
  logic signed [15:0] f2_1_wdata, f2_2_wdata, f2_3_wdata, f2_4_wdata, f2_5_wdata, f2_6_wdata;
  logic        f2_wr_en, f2_done;
  logic [9:0]  f2_waddr;

  logic signed [15:0] pix_mem [6][NPIX];
  logic signed [15:0] obs     [6][196];
  logic signed [15:0] ref_obs [6][196];
  exp_t sb[$];

  int n_checks = 0, n_pass = 0;
  int wr_count, done_count, wrap_count, first_addr;
  logic [9:0] prev_addr;
  int br = 0, bc = 0;

  always #5 clk = ~clk;

  pool1_f2_writer dut (
    .clk(clk), .rst_n(rst_n), .c1_clr(c1_clr), .c1_valid(c1_valid),
    .c1_1_data(c1_1_data), .c1_2_data(c1_2_data), .c1_3_data(c1_3_data),
    .c1_4_data(c1_4_data), .c1_5_data(c1_5_data), .c1_6_data(c1_6_data),
    .f2_1_wdata(f2_1_wdata), .f2_2_wdata(f2_2_wdata), .f2_3_wdata(f2_3_wdata),
    .f2_4_wdata(f2_4_wdata), .f2_5_wdata(f2_5_wdata), .f2_6_wdata(f2_6_wdata),
    .f2_wr_en(f2_wr_en), .f2_waddr(f2_waddr), .f2_done(f2_done)
  );

  function automatic logic signed [15:0] smax(input logic signed [15:0] a, input logic signed [15:0] b);
    return (a > b) ? a : b;
  endfunction

  // Monitor: compare every write against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [5:0][15:0] got;
      got = {f2_6_wdata, f2_5_wdata, f2_4_wdata, f2_3_wdata, f2_2_wdata, f2_1_wdata};
      if (f2_done) begin
        n_checks++;
        if (f2_wr_en !== 1'b1) $display("FAIL done_without_write: wr_en=%b required 1", f2_wr_en);
        else n_pass++;
      end
      if (f2_wr_en) begin
        if (wr_count == 0) first_addr = int'(f2_waddr);
        if (prev_addr == 10'd195 && f2_waddr == 10'd0) wrap_count++;
        prev_addr = f2_waddr;
        wr_count++;
        if (f2_done) done_count++;
        if (f2_waddr < 10'd196)
          for (int k = 0; k < 6; k++) obs[k][f2_waddr] = got[k];
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_write: addr=%0d with empty scoreboard, required no write", f2_waddr);
        end else begin
          exp_t e;
          n_pass++;
          e = sb.pop_front();
          n_checks++;
          if (f2_waddr !== e.addr) $display("FAIL waddr: got %0d required %0d", f2_waddr, e.addr);
          else n_pass++;
          n_checks++;
          if (got !== e.d) $display("FAIL wdata@%0d: got %h required %h", e.addr, got, e.d);
          else n_pass++;
          n_checks++;
          if (f2_done !== e.done) $display("FAIL done@%0d: got %b required %b", e.addr, f2_done, e.done);
          else n_pass++;
        end
      end
    end
  end

  task automatic clear_stats();
    wr_count = 0; done_count = 0; wrap_count = 0; first_addr = -1; prev_addr = '0;
  endtask

  // Drive one pixel at the bench's raster position; push the expected write.
  task automatic drive_pix(input bit clr);
    int i = br * 28 + bc;
    c1_valid = 1'b1;
    c1_clr   = clr;
    c1_1_data = pix_mem[0][i]; c1_2_data = pix_mem[1][i]; c1_3_data = pix_mem[2][i];
    c1_4_data = pix_mem[3][i]; c1_5_data = pix_mem[4][i]; c1_6_data = pix_mem[5][i];
    if (clr) begin
      br = 0; bc = 0;
    end else begin
      if (br[0] && bc[0]) begin
        exp_t e;
        int i0 = (br - 1) * 28 + bc - 1;
        int i2 = br * 28 + bc - 1;
        for (int k = 0; k < 6; k++)
          e.d[k] = smax(smax(pix_mem[k][i0], pix_mem[k][i0 + 1]),
                        smax(pix_mem[k][i2], pix_mem[k][i2 + 1]));
        e.addr = 10'((br / 2) * 14 + bc / 2);
        e.done = (e.addr == 10'd195);
        sb.push_back(e);
      end
      if (bc == 27) begin
        bc = 0;
        br = (br == 27) ? 0 : br + 1;
      end else begin
        bc++;
      end
    end
    @(posedge clk); #1;
    c1_valid = 1'b0;
    c1_clr   = 1'b0;
  endtask

  task automatic drive_frame(input bit gaps);
    for (int n = 0; n < NPIX; n++) begin
      if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      drive_pix(1'b0);
    end
  endtask

  task automatic drain();
    int n = 0;
    repeat (3) @(negedge clk);
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
  endtask

  task automatic fill_random();
    for (int k = 0; k < 6; k++)
      for (int i = 0; i < NPIX; i++) pix_mem[k][i] = 16'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; c1_clr = 1'b0; c1_valid = 1'b0;
    c1_1_data = 0; c1_2_data = 0; c1_3_data = 0; c1_4_data = 0; c1_5_data = 0; c1_6_data = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (f2_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b required 0", f2_wr_en); else n_pass++;
    n_checks++; if (f2_done !== 1'b0) $display("FAIL reset_done: got %b required 0", f2_done); else n_pass++;
    n_checks++; if (f2_waddr !== 10'd0) $display("FAIL reset_waddr: got %0d required 0", f2_waddr); else n_pass++;
    n_checks++; if (f2_1_wdata !== 16'sd0) $display("FAIL reset_wdata: got %0d required 0", f2_1_wdata); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_full_frame();
    fill_random();
    for (int i = 0; i < NPIX; i++) pix_mem[0][i] = 16'((i / 28) * 28 + (i % 28));
    clear_stats();
    drive_frame(1'b0);
    drain();
    n_checks++; if (sb.size() != 0) $display("FAIL full_drain: %0d writes missing, required 0", sb.size()); else n_pass++;
    n_checks++; if (wr_count != 196) $display("FAIL full_count: got %0d required 196", wr_count); else n_pass++;
    n_checks++; if (done_count != 1) $display("FAIL full_done: got %0d pulses required 1", done_count); else n_pass++;
    for (int i = 0; i < 196; i++) begin
      int want = (2 * (i / 14) + 1) * 28 + 2 * (i % 14) + 1;
      n_checks++;
      if (obs[0][i] !== 16'(want)) $display("FAIL full_ch1@%0d: got %0d required %0d", i, obs[0][i], want);
      else n_pass++;
    end
    ref_obs = obs;
  endtask

  task automatic test_gaps();
    clear_stats();
    for (int k = 0; k < 6; k++) for (int i = 0; i < 196; i++) obs[k][i] = 16'sh5a5a;
    drive_frame(1'b1);
    drain();
    n_checks++; if (wr_count != 196) $display("FAIL gaps_count: got %0d required 196", wr_count); else n_pass++;
    for (int i = 0; i < 196; i++) begin
      n_checks++;
      if (obs[0][i] !== ref_obs[0][i] || obs[3][i] !== ref_obs[3][i] || obs[5][i] !== ref_obs[5][i])
        $display("FAIL gaps_match@%0d: got %0d required %0d", i, obs[0][i], ref_obs[0][i]);
      else n_pass++;
    end
  endtask

  task automatic test_signed();
    fill_random();
    for (int i = 0; i < NPIX; i++) begin
      pix_mem[0][i] = -16'sd100;
      pix_mem[1][i] = 16'sd42;
    end
    pix_mem[0][0] = -16'sd5; pix_mem[0][1] = -16'sd3; pix_mem[0][28] = -16'sd9; pix_mem[0][29] = -16'sd7;
    clear_stats();
    drive_frame(1'b0);
    drain();
    n_checks++; if (obs[0][0] !== -16'sd3) $display("FAIL signed_win: got %0d required -3", obs[0][0]); else n_pass++;
    n_checks++; if (obs[0][1] !== -16'sd100) $display("FAIL signed_neg: got %0d required -100", obs[0][1]); else n_pass++;
    n_checks++; if (obs[1][100] !== 16'sd42) $display("FAIL equal_ops: got %0d required 42", obs[1][100]); else n_pass++;
  endtask

  task automatic test_clr();
    fill_random();
    pix_mem[0][300] = 16'sh7fff;
    clear_stats();
    for (int n = 0; n < 300; n++) drive_pix(1'b0);
    drain();
    drive_pix(1'b1);
    @(negedge clk);
    n_checks++; if (f2_wr_en !== 1'b0) $display("FAIL clr_no_write: got %b required 0", f2_wr_en); else n_pass++;
    clear_stats();
    drive_frame(1'b0);
    drain();
    n_checks++; if (first_addr != 0) $display("FAIL clr_first_addr: got %0d required 0", first_addr); else n_pass++;
    n_checks++; if (wr_count != 196) $display("FAIL clr_count: got %0d required 196", wr_count); else n_pass++;
    n_checks++; if (sb.size() != 0) $display("FAIL clr_drain: %0d writes missing, required 0", sb.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    fill_random();
    clear_stats();
    for (int n = 0; n < 500; n++) drive_pix(1'b0);
    n_checks++; if (f2_wr_en !== 1'b1) $display("FAIL mid_pre_write: got %b required 1", f2_wr_en); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (f2_wr_en !== 1'b0) $display("FAIL mid_wr_en: got %b required 0", f2_wr_en); else n_pass++;
    n_checks++; if (f2_done !== 1'b0) $display("FAIL mid_done: got %b required 0", f2_done); else n_pass++;
    n_checks++; if (f2_waddr !== 10'd0) $display("FAIL mid_waddr: got %0d required 0", f2_waddr); else n_pass++;
    sb.delete();
    br = 0; bc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_stats();
    drive_frame(1'b0);
    drain();
    n_checks++; if (wr_count != 196) $display("FAIL mid_count: got %0d required 196", wr_count); else n_pass++;
    n_checks++; if (done_count != 1) $display("FAIL mid_done_cnt: got %0d required 1", done_count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    fill_random();
    clear_stats();
    drive_frame(1'b0);
    drive_frame(1'b0);
    drain();
    n_checks++; if (wr_count != 392) $display("FAIL b2b_count: got %0d required 392", wr_count); else n_pass++;
    n_checks++; if (done_count != 2) $display("FAIL b2b_done: got %0d required 2", done_count); else n_pass++;
    n_checks++; if (wrap_count != 1) $display("FAIL b2b_wrap: got %0d required 1", wrap_count); else n_pass++;
    n_checks++; if (sb.size() != 0) $display("FAIL b2b_drain: %0d writes missing, required 0", sb.size()); else n_pass++;
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_full_frame();
    test_gaps();
    test_signed();
    test_clr();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
